// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - DTC command codes, op enum, frame lengths and FSM state types
// Shared by the DTC transmitter and receiver.
package dtc_pkg;

  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_E2 = 8'hE2;
  localparam logic [7:0] CODE_E4 = 8'hE4;
  localparam logic [7:0] CODE_E8 = 8'hE8;
  localparam logic [7:0] CODE_E9 = 8'hE9;
  localparam logic [7:0] CODE_EA = 8'hEA;
  localparam logic [7:0] CODE_EF = 8'hEF;

  localparam int FRAME_FAST = 8;
  localparam int FRAME_SLOW = 72;
  localparam int GUARD_LEN  = 8;
  localparam int CNT_W      = 7;

  typedef enum logic [2:0] {
    OP_RDOCMD   = 3'd0,
    OP_SCLKSYNC = 3'd1,
    OP_RJECTCMD = 3'd2,
    OP_RSTCMD   = 3'd3,
    OP_STREQ    = 3'd4,
    OP_ARDOEND  = 3'd5,
    OP_SLOW_WR  = 3'd6,
    OP_SLOW_RD  = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    TRIG_IDLE = 2'd0,
    TRIG_HEAD = 2'd1,
    TRIG_LVL  = 2'd2,
    TRIG_TAIL = 2'd3
  } trig_state_e;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_SHIFT = 2'd1,
    CMD_GUARD = 2'd2
  } cmd_state_e;

  function automatic logic is_slow(input cmd_op_e op);
    return (op == OP_SLOW_WR) || (op == OP_SLOW_RD);
  endfunction

  function automatic logic [7:0] fast_code(input cmd_op_e op);
    case (op)
      OP_RDOCMD:   return CODE_E2;
      OP_SCLKSYNC: return CODE_E4;
      OP_RJECTCMD: return CODE_EA;
      OP_RSTCMD:   return CODE_E8;
      OP_STREQ:    return CODE_E9;
      OP_ARDOEND:  return CODE_EF;
      default:     return CODE_E1;
    endcase
  endfunction

  // Frames are left-aligned so the shifter always emits bit 71 first.
  function automatic logic [FRAME_SLOW-1:0] frame_word(input cmd_op_e op,
                                                       input logic [30:0] addr,
                                                       input logic [31:0] data);
    if (is_slow(op)) return {CODE_E1, (op == OP_SLOW_RD), addr, data};
    return {fast_code(op), 64'd0};
  endfunction

  function automatic logic [CNT_W-1:0] frame_len(input cmd_op_e op);
    return is_slow(op) ? CNT_W'(FRAME_SLOW) : CNT_W'(FRAME_FAST);
  endfunction

endpackage

// File: rtl/dtc_tx_shifter.sv
// rtl/dtc_tx_shifter.sv - 72-bit MSB-first load/shift register with bit counter
module dtc_tx_shifter
  import dtc_pkg::*;
(
  input  logic                  dtc_clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_SLOW-1:0] load_word,
  input  logic [CNT_W-1:0]      load_count,
  input  logic                  step,
  output logic                  msb,
  output logic [CNT_W-1:0]      count
);

  logic [FRAME_SLOW-1:0] sreg;

  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      sreg  <= '0;
      count <= '0;
    end else if (load) begin
      sreg  <= load_word;
      count <= load_count;
    end else if (step) begin
      sreg  <= {sreg[FRAME_SLOW-2:0], 1'b0};
      count <= count - 1'b1;
    end
  end

  assign msb = sreg[FRAME_SLOW-1];

endmodule

// File: rtl/dtc_tx.sv
// rtl/dtc_tx.sv - DTC transmitter: trigger lane on dtc_q1, command lane on dtc_q2
// Both lanes feed an external ODDR; they run independently of each other.
module dtc_tx
  import dtc_pkg::*;
(
  input  logic        dtc_clk,
  input  logic        rst,
  input  logic        trig_valid,
  input  logic        trig_is_l1,
  output logic        trig_ready,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [30:0] cmd_address,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic        dtc_q1,
  output logic        dtc_q2
);

  trig_state_e trig_state, trig_next;
  logic        trig_lvl;
  logic        trig_fire;

  assign trig_ready = !rst && ((trig_state == TRIG_IDLE) || (trig_state == TRIG_TAIL));
  assign trig_fire  = trig_valid && trig_ready;

  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      trig_state <= TRIG_IDLE;
      trig_lvl   <= 1'b0;
    end else begin
      trig_state <= trig_next;
      if (trig_fire) trig_lvl <= trig_is_l1;
    end
  end

  always_comb begin
    trig_next = trig_state;
    dtc_q1    = 1'b0;
    case (trig_state)
      TRIG_IDLE: if (trig_fire) trig_next = TRIG_HEAD;
      TRIG_HEAD: begin
        trig_next = TRIG_LVL;
        dtc_q1    = !rst;
      end
      TRIG_LVL: begin
        trig_next = TRIG_TAIL;
        dtc_q1    = !rst && trig_lvl;
      end
      TRIG_TAIL: trig_next = trig_fire ? TRIG_HEAD : TRIG_IDLE;
      default:   trig_next = TRIG_IDLE;
    endcase
  end

  cmd_state_e            cmd_state, cmd_next;
  logic                  sh_load, sh_step, sh_msb;
  logic [FRAME_SLOW-1:0] sh_word, cmd_word;
  logic [CNT_W-1:0]      sh_count, sh_left, cmd_len;
  logic                  cmd_last, cmd_fire;

  assign cmd_word  = frame_word(cmd_op_e'(cmd_op), cmd_address, cmd_data);
  assign cmd_len   = frame_len(cmd_op_e'(cmd_op));
  assign cmd_last  = (sh_left == CNT_W'(1));
  assign cmd_ready = !rst && ((cmd_state == CMD_IDLE) || ((cmd_state == CMD_GUARD) && cmd_last));
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge dtc_clk) begin
    if (rst) cmd_state <= CMD_IDLE;
    else     cmd_state <= cmd_next;
  end

  // The guard interval reuses the bit counter: leaving SHIFT reloads it with GUARD_LEN.
  always_comb begin
    cmd_next = cmd_state;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    sh_word  = '0;
    sh_count = '0;
    dtc_q2   = 1'b0;
    case (cmd_state)
      CMD_IDLE: begin
        if (cmd_fire) begin
          cmd_next = CMD_SHIFT;
          sh_load  = 1'b1;
          sh_word  = cmd_word;
          sh_count = cmd_len;
        end
      end
      CMD_SHIFT: begin
        dtc_q2 = !rst && sh_msb;
        if (cmd_last) begin
          cmd_next = CMD_GUARD;
          sh_load  = 1'b1;
          sh_count = CNT_W'(GUARD_LEN);
        end else begin
          sh_step = 1'b1;
        end
      end
      CMD_GUARD: begin
        if (cmd_last) begin
          if (cmd_fire) begin
            cmd_next = CMD_SHIFT;
            sh_load  = 1'b1;
            sh_word  = cmd_word;
            sh_count = cmd_len;
          end else begin
            cmd_next = CMD_IDLE;
          end
        end else begin
          sh_step = 1'b1;
        end
      end
      default: cmd_next = CMD_IDLE;
    endcase
  end

  dtc_tx_shifter u_shifter (
    .dtc_clk    (dtc_clk),
    .rst        (rst),
    .load       (sh_load),
    .load_word  (sh_word),
    .load_count (sh_count),
    .step       (sh_step),
    .msb        (sh_msb),
    .count      (sh_left)
  );

endmodule

// File: doc/dtc_tx.md
DTC_TX -- requirements
Module: dtc_tx

Interface
REQ-001 SHALL have port dtc_clk  input  1  transmit clock; all logic on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port trig_valid  input  1  trigger request.
REQ-004 SHALL have port trig_is_l1  input  1  trigger level: 0 = L0, 1 = L1; sampled with trig_valid.
REQ-005 SHALL have port trig_ready  output  1  trigger lane can accept a request.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_op  input  3  0 RDOCMD, 1 SCLKSYNC, 2 RJECTCMD, 3 RSTCMD, 4 STREQ, 5 ARDOEND, 6 slow write, 7 slow read.
REQ-008 SHALL have port cmd_address  input  31  slow-command address[30:0].
REQ-009 SHALL have port cmd_data  input  32  slow-command data.
REQ-010 SHALL have port cmd_ready  output  1  command lane can accept a request.
REQ-011 SHALL have port dtc_q1  output  1  rising-edge lane (trigger bits); feeds external ODDR D1, SAME_EDGE.
REQ-012 SHALL have port dtc_q2  output  1  falling-edge lane (command bits); feeds external ODDR D2.

Function
REQ-013 Transfers SHALL occur on valid && ready; the two lanes SHALL be fully independent and may be active in the same cycle.
REQ-014 Trigger FSM SHALL use states IDLE, HEAD, LVL, TAIL: accept in IDLE goes to HEAD; then HEAD -> LVL -> TAIL -> IDLE.
REQ-015 dtc_q1 SHALL be 1 in HEAD, trig_is_l1 (latched at accept) in LVL, and 0 in TAIL and IDLE.
REQ-016 Latency: a trigger accepted at cycle t SHALL drive dtc_q1 = 1 at t+1, the level bit at t+2, and 0 at t+3.
REQ-017 trig_ready SHALL be high in IDLE and TAIL; an accept in TAIL SHALL go directly to HEAD, giving a minimum trigger spacing of 3 cycles.
REQ-018 Fast commands SHALL be serialized MSB-first on dtc_q2 as 8-bit codes: E2, E4, EA, E8, E9, EF for op 0..5.
REQ-019 Slow commands SHALL be serialized as 72 bits MSB-first: header E1, then {rnw, address[30:0], data[31:0]}, where rnw = 1 for op 7 and 0 for op 6.
REQ-020 Command FSM SHALL use states IDLE, SHIFT, GUARD; accept loads the shifter and sets the bit counter to 8 or 72.
REQ-021 A command accepted at cycle t SHALL place its first bit at t+1.
REQ-022 The last bit SHALL appear at t+8 for a fast command or t+72 for a slow command.
REQ-023 GUARD SHALL follow SHIFT and drive 8 zero bits.
REQ-024 dtc_q2 SHALL be 0 whenever the command FSM is not in SHIFT.
REQ-025 cmd_ready SHALL be high in IDLE and in the last GUARD cycle (t+16 for a fast command, t+80 for a slow command); an accept there SHALL restart SHIFT back-to-back with no extra gap.
REQ-026 cmd_address, cmd_data and cmd_op SHALL be captured at accept; later changes SHALL NOT affect the frame in flight.
REQ-027 Request inputs SHALL be ignored while the corresponding ready is low; no request SHALL be queued.

Reset
REQ-028 While rst is high: dtc_q1 = dtc_q2 = 0, trig_ready = cmd_ready = 0, both FSMs in IDLE, shifter and counters cleared.
REQ-029 Both readies SHALL be 1 in the first cycle after rst falls.
REQ-030 rst asserted mid-frame SHALL abort the frame; both lanes SHALL read 0 from the next cycle and no partial frame SHALL resume.

Structure
REQ-031 Package dtc_pkg SHALL hold the command code constants (E1, E2, E4, E8, E9, EA, EF), the cmd_op enum, and the frame lengths 8, 72 and guard 8; the DTC receiver SHALL share it.
REQ-032 One sub-module, dtc_tx_shifter, SHALL hold the 72-bit load/shift register and its bit counter; the ODDR primitive SHALL stay outside dtc_tx.

Verification
REQ-033 The bench SHALL cover: L0 accepted at t=10 -> dtc_q1 = 1,0,0 at t=11..13; trig_ready high at t=13.
REQ-034 The bench SHALL cover: L1 back-to-back, accepts at t=10 and t=13 -> dtc_q1 = 1,1,0,1,1,0 at t=11..16.
REQ-035 The bench SHALL cover: op 0 accepted at t=5 -> dtc_q2 = 1,1,1,0,0,0,1,0 at t=6..13; zeros at t=14..21; cmd_ready high at t=21.
REQ-036 The bench SHALL cover: op 7 with address 0x0000_0123 and data 0xDEAD_BEEF -> 72 bits on dtc_q2 equal E1 followed by 0x8000_0123_DEAD_BEEF.
REQ-037 The bench SHALL cover: loopback through ODDR into the DTC receiver -> exactly one matching fast-command pulse or read/write strobe with equal address/data, and no spurious fast commands.
REQ-038 The bench SHALL cover: rst asserted at bit 30 of a slow frame -> both lanes 0 from the next cycle; the next command is transmitted intact.
